// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - minesweeper sequencing controller
// Drives the datapath command/done handshake with a per-state watchdog and registered Moore outputs.
module game_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       new_game,
  input  logic       guess_valid,
  input  logic [4:0] guess,
  output logic       guess_ready,
  output logic       bad_guess,
  output logic       start,
  output logic       load,
  output logic       decode,
  output logic       alu,
  output logic       display,
  output logic [4:0] data,
  input  logic       place_done,
  input  logic       decode_done,
  input  logic       alu_done,
  input  logic       display_done,
  input  logic       gameover,
  input  logic       win,
  output logic       busy,
  output logic       game_won,
  output logic       game_lost,
  output logic       timeout_err,
  output logic [4:0] moves
);

  typedef enum logic [3:0] {
    S_IDLE, S_PLACE, S_WAIT_GUESS, S_LOAD, S_DECODE,
    S_ALU, S_DISPLAY, S_OVER, S_ERROR
  } state_e;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      moves_q, moves_d;
  logic [4:0]      data_q, data_d;
  logic [24:0]     tried_q, tried_d;
  logic            go_q, go_d;
  logic            win_q, win_d;

  logic guess_ready_q, bad_q, start_q, load_q, decode_q, alu_q, display_q;
  logic busy_q, won_q, lost_q, terr_q;

  logic        cmd_state, done_sel, done_acc;
  logic        guess_bad, accept, reject;
  logic [24:0] guess_mask;

  always_comb begin
    cmd_state = (state_q == S_PLACE) || (state_q == S_DECODE) ||
                (state_q == S_ALU)   || (state_q == S_DISPLAY);
    case (state_q)
      S_PLACE:   done_sel = place_done;
      S_DECODE:  done_sel = decode_done;
      S_ALU:     done_sel = alu_done;
      S_DISPLAY: done_sel = display_done;
      default:   done_sel = 1'b0;
    endcase
    // cnt_q is zero only in the first cycle of a command state, masking stale dones
    done_acc   = cmd_state && done_sel && (cnt_q != '0);
    guess_mask = 25'd1 << guess;
    guess_bad  = (guess >= 5'd25) || ((guess_mask & tried_q) != '0);
    accept     = (state_q == S_WAIT_GUESS) && guess_valid && !new_game && !guess_bad;
    reject     = (state_q == S_WAIT_GUESS) && guess_valid && !new_game && guess_bad;
  end

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    data_d  = data_q;
    tried_d = tried_q;
    go_d    = go_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE:       if (new_game) state_d = S_PLACE;
      S_PLACE:      if (done_acc) state_d = S_WAIT_GUESS;
      S_WAIT_GUESS: begin
        if (new_game) begin
          state_d = S_PLACE;
        end else if (accept) begin
          state_d = S_LOAD;
          data_d  = guess;
          tried_d = tried_q | guess_mask;
          moves_d = moves_q + 5'd1;
        end
      end
      S_LOAD:       state_d = S_DECODE;
      S_DECODE:     if (done_acc) state_d = S_ALU;
      S_ALU: begin
        if (done_acc) begin
          state_d = S_DISPLAY;
          go_d    = gameover;
          win_d   = win;
        end
      end
      S_DISPLAY:    if (done_acc) state_d = go_q ? S_OVER : S_WAIT_GUESS;
      S_OVER:       if (new_game) state_d = S_PLACE;
      S_ERROR:      if (new_game) state_d = S_PLACE;
      default:      state_d = S_IDLE;
    endcase
    if (cmd_state && !done_acc && (cnt_q == TO_LIM)) state_d = S_ERROR;
    if ((state_d == S_PLACE) && (state_q != S_PLACE)) begin
      moves_d = '0;
      tried_d = '0;
      go_d    = 1'b0;
      win_d   = 1'b0;
    end
    cnt_d = ((state_d == state_q) && cmd_state) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      moves_q       <= '0;
      data_q        <= '0;
      tried_q       <= '0;
      go_q          <= 1'b0;
      win_q         <= 1'b0;
      guess_ready_q <= 1'b0;
      bad_q         <= 1'b0;
      start_q       <= 1'b0;
      load_q        <= 1'b0;
      decode_q      <= 1'b0;
      alu_q         <= 1'b0;
      display_q     <= 1'b0;
      busy_q        <= 1'b0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      moves_q       <= moves_d;
      data_q        <= data_d;
      tried_q       <= tried_d;
      go_q          <= go_d;
      win_q         <= win_d;
      // Outputs are decoded from the next state so they are registered, not combinational
      guess_ready_q <= (state_d == S_WAIT_GUESS);
      bad_q         <= reject;
      start_q       <= (state_d == S_PLACE);
      load_q        <= (state_d == S_LOAD);
      decode_q      <= (state_d == S_DECODE);
      alu_q         <= (state_d == S_ALU);
      display_q     <= (state_d == S_DISPLAY);
      busy_q        <= (state_d == S_PLACE) || (state_d == S_DECODE) ||
                       (state_d == S_ALU)   || (state_d == S_DISPLAY);
      won_q         <= (state_d == S_OVER) && win_d;
      lost_q        <= (state_d == S_OVER) && !win_d;
      terr_q        <= (state_d == S_ERROR);
    end
  end

  assign guess_ready = guess_ready_q;
  assign bad_guess   = bad_q;
  assign start       = start_q;
  assign load        = load_q;
  assign decode      = decode_q;
  assign alu         = alu_q;
  assign display     = display_q;
  assign data        = data_q;
  assign busy        = busy_q;
  assign game_won    = won_q;
  assign game_lost   = lost_q;
  assign timeout_err = terr_q;
  assign moves       = moves_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
// Done flags are held as static levels; the controller's stale-done masking makes each command state last two cycles.
module tb_game_ctrl;

  logic       clka = 1'b0;
  logic       restart, new_game, guess_valid;
  logic [4:0] guess;
  logic       guess_ready, bad_guess, start, load, decode, alu, display;
  logic [4:0] data;
  logic       place_done, decode_done, alu_done, display_done, gameover, win;
  logic       busy, game_won, game_lost, timeout_err;
  logic [4:0] moves;

  int n_tests = 0;
  int n_fail  = 0;

  game_ctrl #(.TIMEOUT(15), .TO_W(4)) dut (
    .clka(clka), .restart(restart), .new_game(new_game),
    .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
    .bad_guess(bad_guess), .start(start), .load(load), .decode(decode),
    .alu(alu), .display(display), .data(data), .place_done(place_done),
    .decode_done(decode_done), .alu_done(alu_done), .display_done(display_done),
    .gameover(gameover), .win(win), .busy(busy), .game_won(game_won),
    .game_lost(game_lost), .timeout_err(timeout_err), .moves(moves)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {start, load, decode, alu, display, guess_ready};
  endfunction

  logic [5:0] move_seq [8] = '{6'b010000, 6'b001000, 6'b001000, 6'b000100,
                               6'b000100, 6'b000010, 6'b000010, 6'b000001};
  int dec_cycles;

  initial begin
    restart = 1'b1; new_game = 1'b0; guess_valid = 1'b0; guess = '0;
    place_done = 1'b1; decode_done = 1'b1; alu_done = 1'b1; display_done = 1'b1;
    gameover = 1'b0; win = 1'b0;
    step(); step();
    check("rst_strobes", {26'd0, strobes()}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_moves", {27'd0, moves}, 32'd0);
    check("rst_data", {27'd0, data}, 32'd0);
    check("rst_flags", {28'd0, bad_guess, game_won, game_lost, timeout_err}, 32'd0);

    restart = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("place_c1", {26'd0, strobes()}, 32'b100000);
    check("place_busy", {31'd0, busy}, 32'd1);
    step();
    check("place_c2", {26'd0, strobes()}, 32'b100000);
    step();
    check("wait_ready", {26'd0, strobes()}, 32'b000001);
    check("wait_moves", {27'd0, moves}, 32'd0);

    guess = 5'd7; guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    check("g7_data", {27'd0, data}, 32'd7);
    check("g7_moves", {27'd0, moves}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("g7_seq%0d", i), {26'd0, strobes()}, {26'd0, move_seq[i]});
      if (i < 7) step();
    end

    guess = 5'd7; guess_valid = 1'b1;
    step();
    check("rep7_bad", {31'd0, bad_guess}, 32'd1);
    check("rep7_strobes", {26'd0, strobes()}, 32'b000001);
    guess = 5'd25;
    step();
    check("g25_bad", {31'd0, bad_guess}, 32'd1);
    guess_valid = 1'b0;
    step();
    check("bad_clear", {31'd0, bad_guess}, 32'd0);
    check("bad_moves", {27'd0, moves}, 32'd1);

    gameover = 1'b1; win = 1'b0;
    guess = 5'd12; guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    repeat (7) step();
    check("mine_lost", {30'd0, game_won, game_lost}, 32'b01);
    check("mine_strobes", {26'd0, strobes()}, 32'd0);
    check("mine_moves", {27'd0, moves}, 32'd2);
    gameover = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("ng_place", {26'd0, strobes()}, 32'b100000);
    check("ng_moves", {27'd0, moves}, 32'd0);
    check("ng_result", {30'd0, game_won, game_lost}, 32'd0);
    step(); step();

    decode_done = 1'b0;
    guess = 5'd4; guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    dec_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (decode) dec_cycles++;
      if (timeout_err) break;
    end
    check("to_dec_cycles", dec_cycles, 32'd16);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    check("to_strobes", {26'd0, strobes()}, 32'd0);
    decode_done = 1'b1;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("to_clear", {31'd0, timeout_err}, 32'd0);
    check("to_place", {26'd0, strobes()}, 32'b100000);
    step(); step();

    new_game = 1'b1; guess = 5'd3; guess_valid = 1'b1;
    step();
    new_game = 1'b0; guess_valid = 1'b0;
    check("ngg_place", {26'd0, strobes()}, 32'b100000);
    check("ngg_moves", {27'd0, moves}, 32'd0);
    step(); step();
    guess = 5'd3; guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    check("g3_accept", {26'd0, strobes(), bad_guess}, {25'd0, 7'b0100000});
    check("g3_moves", {27'd0, moves}, 32'd1);
    step(); step(); step();
    check("alu_high", {31'd0, alu}, 32'd1);
    restart = 1'b1;
    #1;
    check("rst_async", {25'd0, alu, busy, moves}, 32'd0);
    restart = 1'b0;
    step();
    check("rst_idle", {26'd0, strobes()}, 32'd0);

    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step(); step();
    guess = 5'd24; guess_valid = 1'b1;
    step();
    guess_valid = 1'b0;
    check("g24_load", {26'd0, strobes()}, 32'b010000);
    check("g24_data", {27'd0, data}, 32'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
